// File: rtl/pad_in_conditioner_3v_if.sv
// Bus between the pad buffer ring and the GPIO/interrupt register file.
// The master drives the raw pad inputs and interrupt controls. The slave
// (the conditioner) returns the debounced levels, edge pulses and interrupt
// flags.
// With PAD_IN_COND_GLITCH_CNT_EN defined, the bus also carries the glitch
// counter clear strobe and the count value.
interface pad_in_conditioner_3v_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] pad_in;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] irq_clr;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] irq_pending;
    logic             irq;
`ifdef PAD_IN_COND_GLITCH_CNT_EN
    logic             glitch_clr;
    logic [7:0]       glitch_cnt;
`endif

    modport master (
`ifdef PAD_IN_COND_GLITCH_CNT_EN
        output glitch_clr,
        input  glitch_cnt,
`endif
        output pad_in, rise_en, fall_en, irq_clr,
        input  level, rise, fall, irq_pending, irq
    );

    modport slave (
`ifdef PAD_IN_COND_GLITCH_CNT_EN
        input  glitch_clr,
        output glitch_cnt,
`endif
        input  pad_in, rise_en, fall_en, irq_clr,
        output level, rise, fall, irq_pending, irq
    );
endinterface

// File: rtl/pad_in_conditioner_3v.sv
// pad_in_conditioner_3v: per-bit conditioning of 3V pad inputs.
// Each bit passes through the following stages:
//   - a two-flop synchronizer,
//   - a consecutive-sample debounce filter,
//   - registered rise/fall pulses,
//   - sticky maskable interrupt-pending flags, OR'd onto a single irq.
// Optional feature macro: PAD_IN_COND_GLITCH_CNT_EN adds an 8-bit
// saturating count of debounce aborts, with a clear strobe.
// Handshake note: there is no valid/ready flow control. Every signal on the
// bus is sampled or updated on every rising clk edge.
module pad_in_conditioner_3v #(
    parameter int   WIDTH     = 8,
    parameter int   DB_BITS   = 4,
    parameter int   DB_COUNT  = 4,
    parameter logic RESET_VAL = 1'b0
) (
    input logic                    clk,
    input logic                    reset,
    pad_in_conditioner_3v_if.slave bus
);

    // Refuse to elaborate when the counter cannot represent DB_COUNT-1.
    generate
        if (DB_COUNT < 1 || DB_COUNT > (2 ** DB_BITS)) begin : g_bad_db_count
            $error("pad_in_conditioner_3v: DB_COUNT out of range 1..2**DB_BITS");
        end
    endgenerate

    localparam logic [DB_BITS-1:0] CNT_MAX = DB_BITS'(DB_COUNT - 1);

    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   r_level;
    logic [WIDTH-1:0]   r_rise;
    logic [WIDTH-1:0]   r_fall;
    logic [WIDTH-1:0]   r_pend;
    logic [DB_BITS-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_done;
    logic [WIDTH-1:0]   w_set;

    assign w_diff = r_sync2 ^ r_level;

    // A bit is accepted once it has differed for DB_COUNT consecutive samples.
    always_comb begin
        w_done = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_done[i] = w_diff[i] && (r_cnt[i] == CNT_MAX);
        end
    end

    // Edge pulses are the registered outputs, so capture lags them by one edge.
    assign w_set = (r_rise & bus.rise_en) | (r_fall & bus.fall_en);

    // Two-flop synchronizer with nothing between the stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= {WIDTH{RESET_VAL}};
            r_sync2 <= {WIDTH{RESET_VAL}};
        end else begin
            r_sync1 <= bus.pad_in;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce counters, stable level and the one-cycle edge pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= {WIDTH{RESET_VAL}};
            r_rise  <= '0;
            r_fall  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_level <= r_level ^ w_done;
            r_rise  <= w_done & r_sync2;
            r_fall  <= w_done & ~r_sync2;
            for (int i = 0; i < WIDTH; i++) begin
                if (!w_diff[i] || w_done[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Sticky pending flags; a new capture beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_set | (r_pend & ~bus.irq_clr);
        end
    end

    assign bus.level       = r_level;
    assign bus.rise        = r_rise;
    assign bus.fall        = r_fall;
    assign bus.irq_pending = r_pend;
    assign bus.irq         = |r_pend;

`ifdef PAD_IN_COND_GLITCH_CNT_EN
    logic [7:0]       r_glitch_cnt;
    logic [WIDTH-1:0] w_abort;

    // An abort is a partial count that collapses because the input returned.
    always_comb begin
        w_abort = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_abort[i] = !w_diff[i] && (r_cnt[i] != '0);
        end
    end

    // Saturating abort counter; clear beats increment.
    always_ff @(posedge clk) begin
        if (reset || bus.glitch_clr) begin
            r_glitch_cnt <= '0;
        end else if ((|w_abort) && (r_glitch_cnt != 8'hFF)) begin
            r_glitch_cnt <= r_glitch_cnt + 8'd1;
        end
    end

    assign bus.glitch_cnt = r_glitch_cnt;
`endif

endmodule

// File: tb/tb_pad_in_conditioner_3v.sv
// Bench for pad_in_conditioner_3v (WIDTH=8, DB_BITS=4, DB_COUNT=4, RESET_VAL=0).
// Structure:
//   - A table of per-cycle vectors, each holding the inputs and the expected
//     outputs after the following rising edge.
//   - A hand-written sequence for reset arriving in the middle of a debounce.
//   - A glitch-counter sequence when PAD_IN_COND_GLITCH_CNT_EN is defined.
module tb_pad_in_conditioner_3v;

    localparam int W = 8;
    localparam int EXP_W = 4 * W + 1;

    typedef struct {
        logic         rst;
        logic [W-1:0] pad;
        logic [W-1:0] ren;
        logic [W-1:0] fen;
        logic [W-1:0] clr;
        logic [W-1:0] lvl;
        logic [W-1:0] rs;
        logic [W-1:0] fl;
        logic [W-1:0] pend;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    vec_t vecs [160];
    int   n_vec = 0;
    logic [EXP_W-1:0] exp_q [$];
    int   n_cmp = 0;
    int   n_fail = 0;

    pad_in_conditioner_3v_if #(.WIDTH(W)) bus ();

    pad_in_conditioner_3v #(
        .WIDTH(W), .DB_BITS(4), .DB_COUNT(4), .RESET_VAL(1'b0)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock.
    always #5 clk = ~clk;

    // Append n identical cycles to the vector table.
    task automatic add_vec(input int n, input logic rst, input logic [W-1:0] pad,
                           input logic [W-1:0] ren, input logic [W-1:0] fen,
                           input logic [W-1:0] clr, input logic [W-1:0] lvl,
                           input logic [W-1:0] rs, input logic [W-1:0] fl,
                           input logic [W-1:0] pend);
        for (int k = 0; k < n; k++) begin
            vecs[n_vec].rst  = rst;
            vecs[n_vec].pad  = pad;
            vecs[n_vec].ren  = ren;
            vecs[n_vec].fen  = fen;
            vecs[n_vec].clr  = clr;
            vecs[n_vec].lvl  = lvl;
            vecs[n_vec].rs   = rs;
            vecs[n_vec].fl   = fl;
            vecs[n_vec].pend = pend;
            n_vec++;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Drive inputs, advance one edge, sample 1 time unit later.
    task automatic drive(input logic rst, input logic [W-1:0] pad, input logic [W-1:0] ren,
                         input logic [W-1:0] fen, input logic [W-1:0] clr);
        reset       = rst;
        bus.pad_in  = pad;
        bus.rise_en = ren;
        bus.fall_en = fen;
        bus.irq_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [EXP_W-1:0] exp_v;
        logic [EXP_W-1:0] act_v;
        logic [W-1:0]     pend_v;
        int               edges;
        logic             seen;
        logic             stray;

        bus.pad_in  = '0;
        bus.rise_en = '0;
        bus.fall_en = '0;
        bus.irq_clr = '0;
`ifdef PAD_IN_COND_GLITCH_CNT_EN
        bus.glitch_clr = 1'b0;
`endif

        // Reset with all pads high, then release: level at 6th edge, pending one later.
        add_vec(1, 1, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        add_vec(5, 0, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        add_vec(1, 0, 8'hFF, 8'h01, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00);
        add_vec(3, 0, 8'hFF, 8'h01, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h01);
        add_vec(1, 0, 8'hFF, 8'h01, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00);
        // Reset with pads low, then a 2-cycle glitch on bit 3 is rejected.
        add_vec(1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        add_vec(2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        add_vec(2, 0, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        add_vec(5, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        // Bit 5 high for 10 cycles then low; only the fall is enabled.
        add_vec(5, 0, 8'h20, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        add_vec(1, 0, 8'h20, 8'h00, 8'h20, 8'h00, 8'h20, 8'h20, 8'h00, 8'h00);
        add_vec(4, 0, 8'h20, 8'h00, 8'h20, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00);
        add_vec(5, 0, 8'h00, 8'h00, 8'h20, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00);
        add_vec(1, 0, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00);
        add_vec(1, 0, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20);
        // Dropping the enable leaves the pending bit alone.
        add_vec(2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20);
        // Unenabled rise, then an enabled fall whose capture meets a clear.
        add_vec(5, 0, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20);
        add_vec(1, 0, 8'h20, 8'h00, 8'h00, 8'h00, 8'h20, 8'h20, 8'h00, 8'h20);
        add_vec(2, 0, 8'h20, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h20);
        add_vec(5, 0, 8'h00, 8'h00, 8'h20, 8'h00, 8'h20, 8'h00, 8'h00, 8'h20);
        add_vec(1, 0, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h20, 8'h20);
        add_vec(1, 0, 8'h00, 8'h00, 8'h20, 8'h20, 8'h00, 8'h00, 8'h00, 8'h20);
        add_vec(1, 0, 8'h00, 8'h00, 8'h20, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00);
        add_vec(1, 0, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        // All bits rise together with both edges enabled.
        add_vec(1, 1, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        add_vec(1, 0, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        add_vec(5, 0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        add_vec(1, 0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00);
        add_vec(1, 0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF);
        // Clear one bit at a time; irq must stay high until the last.
        for (int b = 0; b < W; b++) begin
            pend_v = 8'hFF << (b + 1);
            add_vec(1, 0, 8'hFF, 8'hFF, 8'hFF, 8'(1 << b), 8'hFF, 8'h00, 8'h00, pend_v);
        end
        // All bits fall together.
        add_vec(5, 0, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00);
        add_vec(1, 0, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00);
        add_vec(1, 0, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);

        // Apply the table: push the expectation on drive, pop it on sample.
        for (int i = 0; i < n_vec; i++) begin
            exp_q.push_back({vecs[i].lvl, vecs[i].rs, vecs[i].fl, vecs[i].pend, |vecs[i].pend});
            drive(vecs[i].rst, vecs[i].pad, vecs[i].ren, vecs[i].fen, vecs[i].clr);
            act_v = {bus.level, bus.rise, bus.fall, bus.irq_pending, bus.irq};
            exp_v = exp_q.pop_front();
            check($sformatf("vec%0d", i), 64'(act_v), 64'(exp_v));
        end

        // Reset arriving with bit 1 at cnt=2 throws the partial count away.
        drive(1, 8'h00, 8'h02, 8'h00, 8'h00);
        drive(0, 8'h00, 8'h02, 8'h00, 8'h00);
        stray = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(0, 8'h02, 8'h02, 8'h00, 8'h00);
            stray = stray | (|bus.rise) | (|bus.level);
        end
        drive(1, 8'h02, 8'h02, 8'h00, 8'h00);
        check("mid_reset_no_pulse", 64'({stray, bus.rise, bus.level}), 64'(0));
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            drive(0, 8'h02, 8'h02, 8'h00, 8'h00);
            edges++;
            if (bus.level[1]) begin
                seen = 1'b1;
                check("mid_reset_rise", 64'(bus.rise), 64'(8'h02));
            end
        end
        if (!seen) begin
            check("mid_reset_timeout", 64'(0), 64'(1));
        end else begin
            check("mid_reset_latency", 64'(edges), 64'(6));
        end
        drive(0, 8'h02, 8'h02, 8'h00, 8'h00);
        check("mid_reset_pend", 64'({bus.irq_pending, bus.irq}), 64'({8'h02, 1'b1}));

`ifdef PAD_IN_COND_GLITCH_CNT_EN
        // Bits 2 and 4 glitch together: one abort cycle counts once.
        drive(1, 8'h00, 8'h00, 8'h00, 8'h00);
        check("glitch_cnt_reset", 64'(bus.glitch_cnt), 64'(0));
        drive(0, 8'h00, 8'h00, 8'h00, 8'h00);
        drive(0, 8'h14, 8'h00, 8'h00, 8'h00);
        drive(0, 8'h14, 8'h00, 8'h00, 8'h00);
        for (int k = 0; k < 5; k++) drive(0, 8'h00, 8'h00, 8'h00, 8'h00);
        check("glitch_cnt_one", 64'(bus.glitch_cnt), 64'(1));
        check("glitch_level", 64'(bus.level), 64'(0));
        bus.glitch_clr = 1'b1;
        drive(0, 8'h00, 8'h00, 8'h00, 8'h00);
        bus.glitch_clr = 1'b0;
        check("glitch_cnt_clr", 64'(bus.glitch_cnt), 64'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
